// File: rtl/deal_sequencer.sv
// deal_sequencer
//   Sequences one hand of baccarat-style dealing: two cards each to player
//   and banker, then the third-card rules for both sides, then the result.
//
// Ports
//   slow_clock               in   sole clock, rising edge
//   reset                    in   synchronous, active-high
//   step                     in   deal one card this cycle (dealing states)
//   new_card[3:0]            in   card code (1=A, 2-9, 10, 11=J, 12=Q, 13=K)
//   pcard1..3[3:0]           out  registered player cards, 0 = no card
//   dcard1..3[3:0]           out  registered banker cards, 0 = no card
//   pscore, dscore[3:0]      out  hand scores 0-9, combinational from cards
//   done                     out  hand complete, win flags valid
//   player_win, dealer_win   out  result flags, both high = tie
module deal_sequencer (
  input  logic       slow_clock,
  input  logic       reset,
  input  logic       step,
  input  logic [3:0] new_card,
  output logic [3:0] pcard1,
  output logic [3:0] pcard2,
  output logic [3:0] pcard3,
  output logic [3:0] dcard1,
  output logic [3:0] dcard2,
  output logic [3:0] dcard3,
  output logic [3:0] pscore,
  output logic [3:0] dscore,
  output logic       done,
  output logic       player_win,
  output logic       dealer_win
);

  typedef enum logic [3:0] {
    S_P1    = 4'd0,
    S_D1    = 4'd1,
    S_P2    = 4'd2,
    S_D2    = 4'd3,
    S_EVAL1 = 4'd4,
    S_P3    = 4'd5,
    S_EVAL2 = 4'd6,
    S_D3    = 4'd7,
    S_DONE  = 4'd8
  } state_t;

  state_t state, state_next;

  logic load_p1, load_p2, load_p3;
  logic load_d1, load_d2, load_d3;
  logic banker_draws;
  logic [3:0] p3_value;

  // Face cards, tens and illegal codes (0, 14, 15) all count as zero.
  function automatic logic [3:0] card_value(input logic [3:0] code);
    return (code >= 4'd1 && code <= 4'd9) ? code : 4'd0;
  endfunction

  // Sum of three values is at most 27, so two conditional subtractions
  // give the mod-10 result without a divider.
  function automatic logic [3:0] hand_score(input logic [3:0] a,
                                            input logic [3:0] b,
                                            input logic [3:0] c);
    logic [4:0] sum;
    sum = {1'b0, card_value(a)} + {1'b0, card_value(b)} + {1'b0, card_value(c)};
    if (sum >= 5'd20)      sum = sum - 5'd20;
    else if (sum >= 5'd10) sum = sum - 5'd10;
    return sum[3:0];
  endfunction

  assign pscore   = hand_score(pcard1, pcard2, pcard3);
  assign dscore   = hand_score(dcard1, dcard2, dcard3);
  assign p3_value = card_value(pcard3);

  // Banker third-card table, indexed by banker score and player third card.
  always_comb begin
    banker_draws = 1'b0;
    case (dscore)
      4'd0, 4'd1, 4'd2: banker_draws = 1'b1;
      4'd3:             banker_draws = (p3_value != 4'd8);
      4'd4:             banker_draws = (p3_value >= 4'd2) && (p3_value <= 4'd7);
      4'd5:             banker_draws = (p3_value >= 4'd4) && (p3_value <= 4'd7);
      4'd6:             banker_draws = (p3_value == 4'd6) || (p3_value == 4'd7);
      default:          banker_draws = 1'b0;
    endcase
  end

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_next = state;
    load_p1    = 1'b0;
    load_p2    = 1'b0;
    load_p3    = 1'b0;
    load_d1    = 1'b0;
    load_d2    = 1'b0;
    load_d3    = 1'b0;
    case (state)
      S_P1: if (step) begin load_p1 = 1'b1; state_next = S_D1;    end
      S_D1: if (step) begin load_d1 = 1'b1; state_next = S_P2;    end
      S_P2: if (step) begin load_p2 = 1'b1; state_next = S_D2;    end
      S_D2: if (step) begin load_d2 = 1'b1; state_next = S_EVAL1; end
      S_EVAL1: begin
        if (pscore >= 4'd8 || dscore >= 4'd8) state_next = S_DONE;  // natural
        else if (pscore <= 4'd5)              state_next = S_P3;
        else if (dscore <= 4'd5)              state_next = S_D3;    // player stood
        else                                  state_next = S_DONE;
      end
      S_P3: if (step) begin load_p3 = 1'b1; state_next = S_EVAL2; end
      S_EVAL2: state_next = banker_draws ? S_D3 : S_DONE;
      S_D3: if (step) begin load_d3 = 1'b1; state_next = S_DONE;  end
      S_DONE:  state_next = S_DONE;
      default: state_next = S_P1;
    endcase
  end

  always_comb begin
    done       = (state == S_DONE);
    player_win = done && (pscore >= dscore);
    dealer_win = done && (dscore >= pscore);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge slow_clock) begin
    if (reset) begin
      state <= S_P1;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge slow_clock) begin
    if (reset) begin
      pcard1 <= 4'd0;
      pcard2 <= 4'd0;
      pcard3 <= 4'd0;
      dcard1 <= 4'd0;
      dcard2 <= 4'd0;
      dcard3 <= 4'd0;
    end else begin
      if (load_p1) pcard1 <= new_card;
      if (load_p2) pcard2 <= new_card;
      if (load_p3) pcard3 <= new_card;
      if (load_d1) dcard1 <= new_card;
      if (load_d2) dcard2 <= new_card;
      if (load_d3) dcard3 <= new_card;
    end
  end

endmodule

// File: tb/tb_deal_sequencer.sv
// tb_deal_sequencer
//   Table of complete hands (cards in deal order plus expected final
//   outputs), followed by hand-written sequences for holding, mid-hand
//   reset and the evaluation-state outputs.
module tb_deal_sequencer;

  logic       slow_clock = 1'b0;
  logic       reset;
  logic       step;
  logic [3:0] new_card;
  logic [3:0] pcard1, pcard2, pcard3;
  logic [3:0] dcard1, dcard2, dcard3;
  logic [3:0] pscore, dscore;
  logic       done, player_win, dealer_win;

  int checks = 0;
  int errors = 0;

  deal_sequencer dut (
    .slow_clock (slow_clock),
    .reset      (reset),
    .step       (step),
    .new_card   (new_card),
    .pcard1     (pcard1),
    .pcard2     (pcard2),
    .pcard3     (pcard3),
    .dcard1     (dcard1),
    .dcard2     (dcard2),
    .dcard3     (dcard3),
    .pscore     (pscore),
    .dscore     (dscore),
    .done       (done),
    .player_win (player_win),
    .dealer_win (dealer_win)
  );

  always #5 slow_clock = ~slow_clock;

  typedef struct {
    logic [3:0] cards [6];
    int         n;
    logic [3:0] p1, p2, p3, d1, d2, d3, ps, ds;
    logic       pw, dw;
  } vec_t;

  vec_t vecs [10];

  function automatic vec_t mk(input int c0, input int c1, input int c2,
                              input int c3, input int c4, input int c5,
                              input int n,
                              input int p1, input int p2, input int p3,
                              input int d1, input int d2, input int d3,
                              input int ps, input int ds,
                              input int pw, input int dw);
    vec_t v;
    v.cards[0] = 4'(c0); v.cards[1] = 4'(c1); v.cards[2] = 4'(c2);
    v.cards[3] = 4'(c3); v.cards[4] = 4'(c4); v.cards[5] = 4'(c5);
    v.n  = n;
    v.p1 = 4'(p1); v.p2 = 4'(p2); v.p3 = 4'(p3);
    v.d1 = 4'(d1); v.d2 = 4'(d2); v.d3 = 4'(d3);
    v.ps = 4'(ps); v.ds = 4'(ds);
    v.pw = 1'(pw); v.dw = 1'(dw);
    return v;
  endfunction

  task automatic check4(input string name, input logic [3:0] actual,
                        input logic [3:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic check1(input string name, input logic actual,
                        input logic expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s got %0b expected %0b", name, actual, expected);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge slow_clock);
    #1;
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    step     = 1'b0;
    new_card = 4'd0;
    tick();
    reset = 1'b0;
  endtask

  // One card per step pulse, followed by an idle cycle so that evaluation
  // states are always passed through without a card being offered.
  task automatic deal(input logic [3:0] c);
    step     = 1'b1;
    new_card = c;
    tick();
    step     = 1'b0;
    new_card = 4'd0;
    tick();
  endtask

  task automatic wait_done(input string name);
    int k = 0;
    while (!done && k < 10) begin
      tick();
      k++;
    end
    check1(name, done, 1'b1);
  endtask

  task automatic check_clear(input string tag);
    check4({tag, " pcard1"}, pcard1, 4'd0);
    check4({tag, " pcard2"}, pcard2, 4'd0);
    check4({tag, " pcard3"}, pcard3, 4'd0);
    check4({tag, " dcard1"}, dcard1, 4'd0);
    check4({tag, " dcard2"}, dcard2, 4'd0);
    check4({tag, " dcard3"}, dcard3, 4'd0);
    check4({tag, " pscore"}, pscore, 4'd0);
    check4({tag, " dscore"}, dscore, 4'd0);
    check1({tag, " done"}, done, 1'b0);
    check1({tag, " player_win"}, player_win, 1'b0);
    check1({tag, " dealer_win"}, dealer_win, 1'b0);
  endtask

  initial begin
    reset    = 1'b0;
    step     = 1'b0;
    new_card = 4'd0;

    //            cards in deal order   n  p1 p2 p3  d1 d2 d3  ps ds pw dw
    vecs[0] = mk( 8, 2,10, 3, 0, 0,     4,  8,10, 0,  2, 3, 0,  8, 5, 1, 0); // player natural
    vecs[1] = mk( 2,13, 3, 7, 4, 0,     5,  2, 3, 4, 13, 7, 0,  9, 7, 1, 0); // banker 7 stands
    vecs[2] = mk( 1, 3, 1, 3, 6, 1,     6,  1, 1, 6,  3, 3, 1,  8, 7, 1, 0); // banker 6 vs 6 draws
    vecs[3] = mk( 3, 2, 4, 5, 0, 0,     4,  3, 4, 0,  2, 5, 0,  7, 7, 1, 1); // tie, both stand
    vecs[4] = mk(12, 2, 6, 3, 2, 0,     5, 12, 6, 0,  2, 3, 2,  6, 7, 0, 1); // player stood, banker draws
    vecs[5] = mk( 1, 1, 1, 2, 8, 0,     5,  1, 1, 8,  1, 2, 0,  0, 3, 0, 1); // banker 3 vs 8 stands
    vecs[6] = mk( 1, 2, 1, 2, 1, 0,     5,  1, 1, 1,  2, 2, 0,  3, 4, 0, 1); // banker 4 vs ace stands
    vecs[7] = mk(14, 4,15, 0, 3, 2,     6, 14,15, 3,  4, 0, 2,  3, 6, 0, 1); // illegal codes score 0
    vecs[8] = mk( 1, 4, 1, 5, 0, 0,     4,  1, 1, 0,  4, 5, 0,  2, 9, 0, 1); // banker natural
    vecs[9] = mk( 6, 3,10, 4, 0, 0,     4,  6,10, 0,  3, 4, 0,  6, 7, 0, 1); // both stand, banker higher

    do_reset();
    check_clear("reset");

    for (int i = 0; i < 10; i++) begin
      string t;
      t = $sformatf("v%0d", i);
      do_reset();
      for (int c = 0; c < vecs[i].n; c++) deal(vecs[i].cards[c]);
      wait_done({t, " done"});
      check4({t, " pcard1"}, pcard1, vecs[i].p1);
      check4({t, " pcard2"}, pcard2, vecs[i].p2);
      check4({t, " pcard3"}, pcard3, vecs[i].p3);
      check4({t, " dcard1"}, dcard1, vecs[i].d1);
      check4({t, " dcard2"}, dcard2, vecs[i].d2);
      check4({t, " dcard3"}, dcard3, vecs[i].d3);
      check4({t, " pscore"}, pscore, vecs[i].ps);
      check4({t, " dscore"}, dscore, vecs[i].ds);
      check1({t, " player_win"}, player_win, vecs[i].pw);
      check1({t, " dealer_win"}, dealer_win, vecs[i].dw);
      // Finished hand must ignore further steps.
      deal(4'd9);
      check4({t, " frozen pcard3"}, pcard3, vecs[i].p3);
      check4({t, " frozen dcard3"}, dcard3, vecs[i].d3);
      check1({t, " frozen done"}, done, 1'b1);
    end

    // Hold in S_D1 with step low; new_card toggles but must not load.
    do_reset();
    deal(4'd5);
    new_card = 4'd9;
    repeat (10) tick();
    check4("hold pcard1", pcard1, 4'd5);
    check4("hold dcard1", dcard1, 4'd0);
    check1("hold done", done, 1'b0);
    new_card = 4'd0;
    deal(4'd6);
    check4("hold then deal dcard1", dcard1, 4'd6);
    check4("hold then deal pcard2", pcard2, 4'd0);

    // Reset with step high after two cards: reset wins.
    reset    = 1'b1;
    step     = 1'b1;
    new_card = 4'd7;
    tick();
    reset    = 1'b0;
    step     = 1'b0;
    new_card = 4'd0;
    check_clear("midreset");
    deal(4'd9);
    check4("restart pcard1", pcard1, 4'd9);
    check4("restart dcard1", dcard1, 4'd0);

    // Waiting for the player's third card: not done, no win flags.
    do_reset();
    deal(4'd2); deal(4'd13); deal(4'd3); deal(4'd7);
    check4("p3wait pscore", pscore, 4'd5);
    check4("p3wait dscore", dscore, 4'd7);
    check1("p3wait done", done, 1'b0);
    check1("p3wait player_win", player_win, 1'b0);
    check1("p3wait dealer_win", dealer_win, 1'b0);
    deal(4'd4);
    check4("p3wait pcard3", pcard3, 4'd4);
    check1("p3wait final done", done, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/deal_sequencer.md
DEAL_SEQUENCER -- requirements
Module: deal_sequencer

Interface
REQ-001: The block SHALL have no parameters.
REQ-002: slow_clock  input  1  sole clock; all state updates on rising edge.
REQ-003: reset  input  1  synchronous, active-high reset, sampled on rising edge of slow_clock.
REQ-004: step  input  1  advance request; one card dealt per cycle in which step=1 in a dealing state.
REQ-005: new_card  input  4  card code from card source (1=A, 2-9, 10, 11=J, 12=Q, 13=K).
REQ-006: pcard1, pcard2, pcard3  output  4 each  registered player card codes, 0 = no card (blank display).
REQ-007: dcard1, dcard2, dcard3  output  4 each  registered banker card codes, 0 = no card.
REQ-008: pscore, dscore  output  4 each  current hand scores, 0-9.
REQ-009: done  output  1  hand complete, win flags valid.
REQ-010: player_win, dealer_win  output  1 each  result flags; both high = tie.

Function
REQ-011: Card value SHALL be: codes 1-9 -> code; codes 10-13 -> 0; codes 0, 14, 15 -> 0 (stored unchanged, scored as 0).
REQ-012: pscore/dscore SHALL be (sum of the hand's three card values) mod 10, combinational from the card registers.
REQ-013: FSM states: S_P1, S_D1, S_P2, S_D2, S_EVAL1, S_P3, S_EVAL2, S_D3, S_DONE.
REQ-014: In S_P1, S_D1, S_P2, S_D2, S_P3, S_D3 with step=1: load new_card into pcard1, dcard1, pcard2, dcard2, pcard3, dcard3 respectively; advance next cycle.
REQ-015: In any dealing state with step=0: no register change, state holds indefinitely.
REQ-016: Order: S_P1 -> S_D1 -> S_P2 -> S_D2 -> S_EVAL1.
REQ-017: S_EVAL1 (one cycle, ignores step): pscore>=8 or dscore>=8 (natural) -> S_DONE; else pscore<=5 -> S_P3; else (player stands) dscore<=5 -> S_D3; else -> S_DONE.
REQ-018: S_P3 on step -> S_EVAL2.
REQ-019: S_EVAL2 (one cycle, ignores step), v = value of pcard3; banker draws (-> S_D3) when: dscore<=2; dscore=3 and v!=8; dscore=4 and 2<=v<=7; dscore=5 and 4<=v<=7; dscore=6 and v in {6,7}; dscore=7 never. Otherwise -> S_DONE.
REQ-020: S_D3 on step -> S_DONE.
REQ-021: S_DONE SHALL hold until reset; step ignored; card registers frozen.
REQ-022: done=1 iff state is S_DONE.
REQ-023: In S_DONE: player_win = (pscore>=dscore), dealer_win = (dscore>=pscore); both 0 in all other states.
REQ-024: Dealing latency: cards appear on pcardN/dcardN the cycle after the step edge; done asserts the cycle after the final transition into S_DONE.

Reset
REQ-025: reset=1 at a rising edge SHALL force state S_P1 and all six card registers to 0, regardless of current state or step.
REQ-026: After reset: pscore=dscore=0, done=0, player_win=dealer_win=0.
REQ-027: Reset mid-hand SHALL discard all dealt cards; reset has priority over step.

Verification
REQ-028: Natural: step with cards 8,2,10,3 -> after 4 steps + EVAL1, S_DONE; pscore=8, dscore=5, player_win=1, dealer_win=0; pcard3=dcard3=0.
REQ-029: Player draws, banker 7 stands: cards 2,13,3,7 then P3=4 -> pscore=9, dscore=7, no dcard3, player_win=1.
REQ-030: Banker 6 vs third card 6: cards 1,3,1,3 then P3=6 -> banker draws; D3=1 -> pscore=8, dscore=7, player_win=1.
REQ-031: Tie with both standing: cards 3,2,4,5 -> pscore=7, dscore=7, no third cards, player_win=dealer_win=1.
REQ-032: step held 0 for 10 cycles in S_D1 -> no register change; reset asserted after two cards -> next cycle all cards 0, done=0, dealing restarts at pcard1.
REQ-033: Player stood, banker draws: cards 12,2,6,3 -> pscore=6, dscore=5 -> S_D3; D3=2 -> dscore=7, dealer_win=1, player_win=0.
